// File: rtl/fastserial_ftdi_endpoint_if.sv
// Signal bundle between the FT2232H fast-serial endpoint model and the FPGA-side logic/bench.
// The endpoint uses the slave modport; the FPGA side (or a bench) uses master.
interface fastserial_ftdi_endpoint_if #(
   parameter int unsigned RX_DEPTH = 8
);
   localparam int unsigned LVL_W = $clog2(RX_DEPTH) + 1;

   logic             i_fsclk;
   logic             i_fsdi;
   logic             o_fsdo;
   logic             o_fscts;
   logic [7:0]       o_rx_data;
   logic             o_rx_port;
   logic             o_rx_valid;
   logic             i_rx_ready;
   logic [LVL_W-1:0] o_rx_level;
   logic             o_overrun;
   logic [7:0]       i_tx_data;
   logic             i_tx_port;
   logic             i_tx_valid;
   logic             o_tx_ready;

   modport slave (
      input  i_fsclk, i_fsdi, i_rx_ready, i_tx_data, i_tx_port, i_tx_valid,
      output o_fsdo, o_fscts, o_rx_data, o_rx_port, o_rx_valid, o_rx_level, o_overrun,
             o_tx_ready
   );

   modport master (
      output i_fsclk, i_fsdi, i_rx_ready, i_tx_data, i_tx_port, i_tx_valid,
      input  o_fsdo, o_fscts, o_rx_data, o_rx_port, o_rx_valid, o_rx_level, o_overrun,
             o_tx_ready
   );
endinterface

// File: rtl/fastserial_ftdi_endpoint.sv
// FT2232H far end of the FTDI fast opto-isolated serial link: receives frames on FSDI into a
// fall-through FIFO and transmits frames on FSDO, both clocked by the FPGA-supplied FSCLK.
module fastserial_ftdi_endpoint #(
   parameter int unsigned RX_DEPTH    = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned GAP_BITS    = 1
) (
   input logic                       i_clk,
   input logic                       i_reset,
   fastserial_ftdi_endpoint_if.slave bus
);
   localparam int unsigned PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(RX_DEPTH) + 1;
   localparam int unsigned GAP_W = $clog2(GAP_BITS) + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(RX_DEPTH);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

   typedef enum logic [1:0] {StRxIdle, StRxData, StRxPort} rx_state_e;
   typedef enum logic [1:0] {StTxIdle, StTxShift, StTxGap} tx_state_e;

   logic [SYNC_STAGES-1:0] fsclk_sync_q, fsdi_sync_q;
   logic                   fsclk_prev_q;
   logic                   fsclk_s, fsdi_s, fs_rise, fs_fall;

   // fsdi passes through the same number of stages so it lines up with the detected rise
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         fsclk_sync_q <= '0;
         fsdi_sync_q  <= '1;
         fsclk_prev_q <= 1'b0;
      end else begin
         fsclk_sync_q[0] <= bus.i_fsclk;
         fsdi_sync_q[0]  <= bus.i_fsdi;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            fsclk_sync_q[i] <= fsclk_sync_q[i-1];
            fsdi_sync_q[i]  <= fsdi_sync_q[i-1];
         end
         fsclk_prev_q <= fsclk_s;
      end
   end

   assign fsclk_s = fsclk_sync_q[SYNC_STAGES-1];
   assign fsdi_s  = fsdi_sync_q[SYNC_STAGES-1];
   assign fs_rise = fsclk_s & ~fsclk_prev_q;
   assign fs_fall = ~fsclk_s & fsclk_prev_q;

   rx_state_e        rx_state_q, rx_state_d;
   logic [2:0]       rx_bits_q, rx_bits_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             push, push_port;
   logic [8:0]       mem_q [RX_DEPTH];
   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [LVL_W-1:0] level_q, level_d;
   logic             fscts_q, overrun_q;
   logic             full, empty, pop, wr_en;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_bits_d  = rx_bits_q;
      rx_shift_d = rx_shift_q;
      push       = 1'b0;
      push_port  = 1'b0;
      if (fs_rise) begin
         unique case (rx_state_q)
            StRxIdle: begin
               rx_bits_d = '0;
               if (!fsdi_s) rx_state_d = StRxData;
            end
            StRxData: begin
               rx_shift_d = {fsdi_s, rx_shift_q[7:1]};
               rx_bits_d  = rx_bits_q + 3'd1;
               if (rx_bits_q == 3'd7) rx_state_d = StRxPort;
            end
            StRxPort: begin
               push       = 1'b1;
               push_port  = fsdi_s;
               rx_state_d = StRxIdle;
            end
            default: rx_state_d = StRxIdle;
         endcase
      end
   end

   assign full  = (level_q == LVL_FULL);
   assign empty = (level_q == '0);
   assign pop   = bus.i_rx_ready & ~empty;
   // A full FIFO still accepts a push when the same cycle frees an entry
   assign wr_en = push & (~full | pop);

   always_comb begin
      level_d = level_q;
      if (wr_en && !pop)      level_d = level_q + 1'b1;
      else if (!wr_en && pop) level_d = level_q - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rx_state_q <= StRxIdle;
         rx_bits_q  <= '0;
         rx_shift_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         fscts_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_bits_q  <= rx_bits_d;
         rx_shift_q <= rx_shift_d;
         level_q    <= level_d;
         fscts_q    <= (level_d < LVL_FULL);
         overrun_q  <= push & full & ~pop;
         if (wr_en) wptr_q <= wptr_q + 1'b1;
         if (pop)   rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wptr_q] <= {push_port, rx_shift_q};
   end

   assign {bus.o_rx_port, bus.o_rx_data} = mem_q[rptr_q];
   assign bus.o_rx_valid = ~empty;
   assign bus.o_rx_level = level_q;
   assign bus.o_fscts    = fscts_q;
   assign bus.o_overrun  = overrun_q;

   tx_state_e        tx_state_q, tx_state_d;
   logic [8:0]       hold_q, hold_d, tx_shift_q, tx_shift_d;
   logic             hold_full_q, hold_full_d, tx_ready_q;
   logic [3:0]       tx_cnt_q, tx_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             fsdo_q, fsdo_d, tx_load, tx_accept;

   assign tx_accept = bus.i_tx_valid & tx_ready_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      fsdo_d     = fsdo_q;
      tx_load    = 1'b0;
      unique case (tx_state_q)
         StTxIdle: if (fs_fall && hold_full_q) begin
            tx_load    = 1'b1;
            tx_shift_d = hold_q;
            tx_cnt_d   = '0;
            fsdo_d     = 1'b0;
            tx_state_d = StTxShift;
         end
         StTxShift: if (fs_fall) begin
            fsdo_d     = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[8:1]};
            tx_cnt_d   = tx_cnt_q + 4'd1;
            if (tx_cnt_q == 4'd8) begin
               gap_cnt_d  = '0;
               tx_state_d = StTxGap;
            end
         end
         StTxGap: if (fs_fall) begin
            fsdo_d    = 1'b1;
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_cnt_q == GAP_LAST) tx_state_d = StTxIdle;
         end
         default: tx_state_d = StTxIdle;
      endcase

      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (tx_load) hold_full_d = 1'b0;
      if (tx_accept) begin
         hold_d      = {bus.i_tx_port, bus.i_tx_data};
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tx_state_q  <= StTxIdle;
         tx_shift_q  <= '0;
         tx_cnt_q    <= '0;
         gap_cnt_q   <= '0;
         fsdo_q      <= 1'b1;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_ready_q  <= 1'b0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_shift_q  <= tx_shift_d;
         tx_cnt_q    <= tx_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         fsdo_q      <= fsdo_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_ready_q  <= ~hold_full_d;
      end
   end

   assign bus.o_fsdo     = fsdo_q;
   assign bus.o_tx_ready = tx_ready_q;
endmodule

// File: tb/tb_fastserial_ftdi_endpoint.sv
// Self-checking bench for fastserial_ftdi_endpoint: the bench plays the FPGA side of the link,
// keeps a queue model of the RX FIFO and decodes FSDO frames independently.
`timescale 1ns/1ps
module tb_fastserial_ftdi_endpoint;
   localparam int RX_DEPTH    = 8;
   localparam int SYNC_STAGES = 2;
   localparam int GAP_BITS    = 1;

   logic       clk = 1'b0, reset = 1'b1, fsclk = 1'b0;
   logic       tb_fsdi = 1'b1, loop_en = 1'b0, rx_ready = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_port = 1'b0, tx_valid = 1'b0;

   fastserial_ftdi_endpoint_if #(.RX_DEPTH(RX_DEPTH)) bus ();

   assign bus.i_fsclk    = fsclk;
   assign bus.i_fsdi     = loop_en ? bus.o_fsdo : tb_fsdi;
   assign bus.i_rx_ready = rx_ready;
   assign bus.i_tx_data  = tx_data;
   assign bus.i_tx_port  = tx_port;
   assign bus.i_tx_valid = tx_valid;

   fastserial_ftdi_endpoint #(
      .RX_DEPTH   (RX_DEPTH),
      .SYNC_STAGES(SYNC_STAGES),
      .GAP_BITS   (GAP_BITS)
   ) dut (
      .i_clk  (clk),
      .i_reset(reset),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always #60 fsclk = ~fsclk;

   int         n_cmp = 0, n_fail = 0, ovr_cnt = 0, exp_ovr = 0;
   logic [8:0] model_q[$];
   logic [8:0] tx_frames[$];
   logic       fsdo_log[$];
   logic       mon_prev = 1'b0, mon_busy = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_bits = 8'h00;

   // FPGA-side view of FSDO: sampled at each FSCLK rise and decoded into {port, byte}
   always @(negedge clk) begin
      if (bus.o_overrun) ovr_cnt <= ovr_cnt + 1;
      mon_prev <= fsclk;
      if (reset) begin
         mon_busy <= 1'b0;
         mon_cnt  <= 0;
      end else if (fsclk && !mon_prev) begin
         fsdo_log.push_back(bus.o_fsdo);
         if (!mon_busy) begin
            if (!bus.o_fsdo) begin
               mon_busy <= 1'b1;
               mon_cnt  <= 0;
            end
         end else if (mon_cnt == 8) begin
            tx_frames.push_back({bus.o_fsdo, mon_bits});
            mon_busy <= 1'b0;
         end else begin
            mon_bits[mon_cnt] <= bus.o_fsdo;
            mon_cnt <= mon_cnt + 1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1; tb_fsdi = 1'b1; rx_ready = 1'b0; tx_valid = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(2);
      model_q.delete();
   endtask

   // Sends one frame; with pop_at_end, a pop is timed onto the cycle that pushes this frame
   task automatic send_frame(input logic [7:0] d, input logic p, input bit pop_at_end);
      @(negedge fsclk); tb_fsdi = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge fsclk); tb_fsdi = d[i];
      end
      @(negedge fsclk); tb_fsdi = p;
      if (pop_at_end) begin
         @(posedge fsclk);
         repeat (SYNC_STAGES) @(posedge clk);
         @(negedge clk); rx_ready = 1'b1;
         @(negedge clk); rx_ready = 1'b0;
      end
      @(negedge fsclk); tb_fsdi = 1'b1;
      tick(2);
   endtask

   task automatic model_frame(input logic [8:0] w);
      if (model_q.size() < RX_DEPTH) model_q.push_back(w);
      else exp_ovr++;
   endtask

   task automatic pop_one(output logic [8:0] got);
      @(negedge clk);
      got = {bus.o_rx_port, bus.o_rx_data};
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] d, input logic p);
      @(negedge clk);
      tx_data = d; tx_port = p; tx_valid = 1'b1;
      for (int c = 0; c < 5000; c++) begin
         if (bus.o_tx_ready) begin
            @(negedge clk);
            tx_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      tx_valid = 1'b0;
      n_cmp++; n_fail++;
      $display("FAIL tx_accept: o_tx_ready stayed 0, required 1 within 5000 cycles");
   endtask

   task automatic wait_tx_frames(input int target);
      for (int c = 0; c < 20000 && tx_frames.size() < target; c++) @(negedge clk);
      n_cmp++;
      if (tx_frames.size() < target) begin
         n_fail++;
         $display("FAIL tx_frame_count: got %0d required %0d", tx_frames.size(), target);
      end
   endtask

   task automatic test_drain(input string tag);
      logic [8:0] got, exp;
      while (model_q.size() > 0) begin
         pop_one(got);
         exp = model_q.pop_front();
         n_cmp++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s_drain: got %h required %h", tag, got, exp);
         end
      end
      n_cmp++;
      if ({bus.o_rx_valid, bus.o_rx_level} !== 5'b0) begin
         n_fail++;
         $display("FAIL %s_empty: valid/level %b required 0", tag, {bus.o_rx_valid, bus.o_rx_level});
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      n_cmp++;
      if ({bus.o_fsdo, bus.o_fscts, bus.o_rx_valid, bus.o_rx_level, bus.o_overrun, bus.o_tx_ready}
          !== 9'b1_0_0_0000_0_0) begin
         n_fail++;
         $display("FAIL reset_values: got %b required 100000000", {bus.o_fsdo, bus.o_fscts,
                  bus.o_rx_valid, bus.o_rx_level, bus.o_overrun, bus.o_tx_ready});
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.o_fscts, bus.o_tx_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL post_reset_ready: cts/tx_ready %b required 11", {bus.o_fscts, bus.o_tx_ready});
      end
   endtask

   task automatic test_rx_single();
      send_frame(8'hA5, 1'b0, 1'b0);
      model_frame({1'b0, 8'hA5});
      n_cmp++;
      if ({bus.o_rx_valid, bus.o_rx_level, bus.o_rx_port, bus.o_rx_data} !== {1'b1, 4'd1, 9'h0A5})
      begin
         n_fail++;
         $display("FAIL rx_single: got v=%b lvl=%0d p=%b d=%h required v=1 lvl=1 p=0 d=a5",
                  bus.o_rx_valid, bus.o_rx_level, bus.o_rx_port, bus.o_rx_data);
      end
   endtask

   task automatic test_tx_pattern();
      int         idx, j;
      logic [7:0] d;
      logic [10+GAP_BITS-1:0] exp, got;
      d = 8'h3C;
      exp = '1;
      exp[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp[1+i] = d[i];
      exp[9] = 1'b1;
      idx = fsdo_log.size();
      push_tx(d, 1'b1);
      for (int c = 0; c < 20000 && fsdo_log.size() < idx + 30; c++) @(negedge clk);
      j = idx;
      while (j < fsdo_log.size() && fsdo_log[j] !== 1'b0) j++;
      got = '1;
      for (int i = 0; i < 10 + GAP_BITS; i++)
         if (j + i < fsdo_log.size()) got[i] = fsdo_log[j+i]; else got[i] = 1'bx;
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL tx_pattern: bits (lsb=first) %b required %b", got, exp);
      end
   endtask

   task automatic test_tx_random();
      int         base;
      logic [8:0] exp[$];
      base = tx_frames.size();
      for (int k = 0; k < 4; k++) begin
         exp.push_back(9'($urandom));
         push_tx(exp[k][7:0], exp[k][8]);
      end
      wait_tx_frames(base + 4);
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (base + k >= tx_frames.size() || tx_frames[base+k] !== exp[k]) begin
            n_fail++;
            $display("FAIL tx_random_%0d: got %h required %h", k,
                     (base + k < tx_frames.size()) ? tx_frames[base+k] : 9'hxxx, exp[k]);
         end
      end
   endtask

   task automatic test_rx_random();
      logic [8:0] w, got, exp;
      int         ovr0, npop;
      test_drain("rx_random_pre");
      ovr0 = ovr_cnt; exp_ovr = 0;
      for (int k = 0; k < 14; k++) begin
         w = 9'($urandom);
         send_frame(w[7:0], w[8], 1'b0);
         model_frame(w);
         n_cmp++;
         if ({bus.o_rx_valid, bus.o_rx_level, bus.o_rx_port, bus.o_rx_data} !==
             {1'b1, 4'(model_q.size()), model_q[0]}) begin
            n_fail++;
            $display("FAIL rx_random_%0d: v/lvl/head %b/%0d/%h required 1/%0d/%h", k,
                     bus.o_rx_valid, bus.o_rx_level, {bus.o_rx_port, bus.o_rx_data},
                     model_q.size(), model_q[0]);
         end
         npop = $urandom_range(0, 1) + ((k % 5 == 4) ? 2 : 0);
         for (int p = 0; p < npop; p++) begin
            pop_one(got);
            if (model_q.size() > 0) begin
               exp = model_q.pop_front();
               n_cmp++;
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL rx_random_pop: got %h required %h", got, exp);
               end
            end
         end
      end
      n_cmp++;
      if (ovr_cnt - ovr0 != exp_ovr) begin
         n_fail++;
         $display("FAIL rx_random_overrun: got %0d pulses required %0d", ovr_cnt - ovr0, exp_ovr);
      end
   endtask

   task automatic test_fifo_full();
      logic [8:0] w;
      int         ovr0;
      test_drain("full_pre");
      for (int k = 0; k < RX_DEPTH; k++) begin
         w = 9'($urandom);
         send_frame(w[7:0], w[8], 1'b0);
         model_frame(w);
         n_cmp++;
         if (bus.o_fscts !== (k < RX_DEPTH - 1)) begin
            n_fail++;
            $display("FAIL full_cts_%0d: got %b required %b", k, bus.o_fscts, k < RX_DEPTH - 1);
         end
      end
      ovr0 = ovr_cnt;
      w = 9'($urandom);
      send_frame(w[7:0], w[8], 1'b0);
      n_cmp++;
      if (ovr_cnt - ovr0 != 1 || bus.o_rx_level !== 4'(RX_DEPTH) ||
          {bus.o_rx_port, bus.o_rx_data} !== model_q[0]) begin
         n_fail++;
         $display("FAIL full_overrun: pulses %0d lvl %0d head %h required 1 %0d %h", ovr_cnt - ovr0,
                  bus.o_rx_level, {bus.o_rx_port, bus.o_rx_data}, RX_DEPTH, model_q[0]);
      end
   endtask

   task automatic test_full_push_pop();
      logic [8:0] w;
      int         ovr0;
      ovr0 = ovr_cnt;
      w = 9'($urandom);
      send_frame(w[7:0], w[8], 1'b1);
      void'(model_q.pop_front());
      model_q.push_back(w);
      n_cmp++;
      if (ovr_cnt != ovr0 || bus.o_rx_level !== 4'(RX_DEPTH) || bus.o_fscts !== 1'b0) begin
         n_fail++;
         $display("FAIL full_push_pop: pulses %0d lvl %0d cts %b required 0 %0d 0", ovr_cnt - ovr0,
                  bus.o_rx_level, bus.o_fscts, RX_DEPTH);
      end
      test_drain("full_push_pop");
   endtask

   task automatic test_reset_midframe();
      logic [8:0] w;
      int         idx, j, base;
      for (int k = 0; k < 3; k++) send_frame(8'($urandom), 1'b1, 1'b0);
      w = 9'($urandom);
      @(negedge fsclk); tb_fsdi = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge fsclk); tb_fsdi = w[i];
      end
      @(posedge fsclk);
      tick(4);
      pulse_reset();
      n_cmp++;
      if ({bus.o_fsdo, bus.o_rx_valid, bus.o_rx_level} !== 6'b1_0_0000) begin
         n_fail++;
         $display("FAIL rx_midframe_reset: fsdo/valid/lvl %b required 100000",
                  {bus.o_fsdo, bus.o_rx_valid, bus.o_rx_level});
      end
      send_frame(8'h5A, w[8], 1'b0);
      model_frame({w[8], 8'h5A});
      n_cmp++;
      if ({bus.o_rx_level, bus.o_rx_port, bus.o_rx_data} !== {4'd1, w[8], 8'h5A}) begin
         n_fail++;
         $display("FAIL rx_after_reset: lvl %0d head %h required 1 %h", bus.o_rx_level,
                  {bus.o_rx_port, bus.o_rx_data}, {w[8], 8'h5A});
      end
      idx = fsdo_log.size();
      push_tx(8'($urandom), 1'b0);
      j = -1;
      for (int c = 0; c < 20000; c++) begin
         if (j < 0)
            for (int i = idx; i < fsdo_log.size(); i++) if (j < 0 && fsdo_log[i] === 1'b0) j = i;
         if (j >= 0 && fsdo_log.size() >= j + 6) break;
         @(negedge clk);
      end
      pulse_reset();
      n_cmp++;
      if ({bus.o_fsdo, bus.o_tx_ready, bus.o_rx_level} !== 6'b1_1_0000) begin
         n_fail++;
         $display("FAIL tx_midframe_reset: fsdo/tx_ready/lvl %b required 110000",
                  {bus.o_fsdo, bus.o_tx_ready, bus.o_rx_level});
      end
      base = tx_frames.size();
      push_tx(8'h5A, w[8]);
      wait_tx_frames(base + 1);
      n_cmp++;
      if (tx_frames.size() != base + 1 || tx_frames[base] !== {w[8], 8'h5A}) begin
         n_fail++;
         $display("FAIL tx_after_reset: frames %0d last %h required %0d %h", tx_frames.size(),
                  (tx_frames.size() > base) ? tx_frames[base] : 9'hxxx, base + 1, {w[8], 8'h5A});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      logic       p;
      bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81;
      test_drain("b2b_pre");
      loop_en = 1'b1;
      tick(2);
      for (int k = 0; k < 3; k++) begin
         p = 1'($urandom);
         push_tx(bytes[k], p);
         model_q.push_back({p, bytes[k]});
      end
      for (int c = 0; c < 20000 && bus.o_rx_level != 4'd3; c++) @(negedge clk);
      tick(200);
      loop_en = 1'b0;
      n_cmp++;
      if (bus.o_rx_level !== 4'd3) begin
         n_fail++;
         $display("FAIL b2b_level: got %0d required 3", bus.o_rx_level);
      end
      test_drain("b2b");
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rx_single();
      test_tx_pattern();
      test_tx_random();
      test_rx_random();
      test_fifo_full();
      test_full_push_pop();
      test_reset_midframe();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
